pe_mac_pipe: RTL and testbench
==============================

Name: pe_mac_pipe

Overview:
- Parametrised, fully pipelined multiply-accumulate processing element; successor to the single-cycle combinational DSP multiply-add PE in the convolution datapath.
- Adds configurable operand/result widths, a fixed 3-stage pipeline with valid tracking, and run-time modes: multiply-add, multiply-subtract, multiply-only and self-accumulate with first/last framing.
- Adds optional saturation with an overflow flag.
- Sits in the PE array between the feature-map/weight fetch logic and the partial-sum adders; maps onto one DSP slice per instance.

Parameters:
- A_WIDTH, 30, signed data operand width.
- B_WIDTH, 18, signed weight operand width.
- OUT_WIDTH, 48, signed result and partial-sum width; must be >= A_WIDTH+B_WIDTH.
- SATURATE, 0, 1 = clamp the result to the OUT_WIDTH signed range; 0 = two's-complement wrap.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_en  in  1  input valid; the sample is accepted on any cycle where i_en=1.
- i_mode  in  2  operation mode: 0 MUL_ADD, 1 MUL_SUB, 2 MUL, 3 ACC.
- i_first  in  1  ACC mode only: this sample starts a new accumulation.
- i_last  in  1  ACC mode only: this sample ends the accumulation.
- i_data  in  A_WIDTH  signed data operand.
- i_weight  in  B_WIDTH  signed weight operand.
- i_partoutvalue  in  OUT_WIDTH  signed partial sum C, used in MUL_ADD and MUL_SUB.
- o_en  out  1  result valid.
- o_last  out  1  ACC mode: final accumulated value; 0 in all other modes.
- o_ovf  out  1  overflow or saturation occurred on this result.
- o_data  out  OUT_WIDTH  signed result.

Behaviour:
- Reset: i_rst=1 clears all pipeline valids, the accumulator and all outputs on the next edge. After reset, o_en=0, o_last=0, o_ovf=0 and o_data=0.
- Reset has priority over i_en. Samples in flight when reset is asserted are discarded; no o_en is produced for them.
- Stage 1 (S1): on i_en=1, register data, weight, C, mode, first and last. On i_en=0, set S1 valid=0; the data registers may hold their previous contents.
- Stage 2 (S2): product M = data*weight at full A_WIDTH+B_WIDTH width, sign-extended to OUT_WIDTH+1. C, mode, first and last are carried forward alongside valid.
- Stage 3 (S3): compute R at OUT_WIDTH+1 bits according to the mode:
  - MUL_ADD: R = C + M.
  - MUL_SUB: R = C - M.
  - MUL: R = M.
  - ACC with first=1: R = M.
  - ACC with first=0: R = acc + M.
- Output register: o_data is R, wrapped or saturated to OUT_WIDTH. o_en is the S2 valid delayed one cycle. Fixed latency is 3 cycles from i_en to o_en. Throughput is 1 sample per cycle with no stalls.
- Overflow: o_ovf=1 when R lies outside the OUT_WIDTH signed range.
  - SATURATE=1: o_data clamps to +2^(OUT_WIDTH-1)-1 or -2^(OUT_WIDTH-1).
  - SATURATE=0: o_data is the low OUT_WIDTH bits.
  - o_ovf is flagged per result and is not sticky.
- Accumulator: updated to the stored o_data value only on valid ACC results, so that saturation is respected. Invalid cycles (bubbles) leave acc untouched, so a gapped ACC stream accumulates correctly.
- ACC mode outputs:
  - Every valid ACC result asserts o_en with the running sum.
  - o_last=1 only for a result whose sample had i_last=1.
  - i_first=1 and i_last=1 together give a single-term accumulation: o_data=M, o_last=1.
- Mode mixing: mode may change on any sample. A non-ACC result does not modify acc. An ACC sample with first=0 following non-ACC samples continues from the last acc value.
- When o_en=0, o_data, o_last and o_ovf hold their previous values. o_last and o_ovf are qualified by o_en.
- i_first and i_last are ignored when i_mode≠3.

Test Plan:
- Reset, then MUL_ADD with data=3, weight=-4, C=100 on cycle 0 -> o_en=1 on cycle 3 with o_data=88, o_ovf=0; o_en=0 on cycles 1–2 and 4.
- Back-to-back stream of MUL_SUB, MUL, MUL_ADD with (5,6,C=10), (-7,8,C=x), (2,2,C=-1) -> consecutive o_data values -20, -56, 3 on cycles 3, 4, 5.
- ACC with data={1,2,3,4}, weight=10, first on sample 0, last on sample 3, and a 2-cycle bubble between samples 1 and 2 -> o_data values 10, 30, 60, 100; o_last=1 only with 100. Repeat immediately with first=1 -> restarts at 10.
- SATURATE=1, OUT_WIDTH=48, MUL_ADD with C=2^47-1, data=1, weight=1 -> o_data=2^47-1, o_ovf=1. With SATURATE=0 -> o_data=-2^47, o_ovf=1.
- Assert i_rst for 1 cycle while 3 samples are in flight -> no o_en for those samples; o_data=0. A following ACC with first=0 starts from acc=0.
- Min/max operands: data=-2^29, weight=-2^17 in MUL -> o_data=2^46, o_ovf=0.

Source files
------------

// File: rtl/pe_mac_pipe.sv
// Pipelined signed multiply-accumulate PE for the convolution datapath.
// Three register stages (operands, product, result) with valid tracking,
// run-time MUL_ADD / MUL_SUB / MUL / ACC modes and optional saturation.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst          synchronous active-high reset
//   i_en           input sample valid
//   i_mode         0 MUL_ADD, 1 MUL_SUB, 2 MUL, 3 ACC
//   i_first        ACC: sample starts a new accumulation
//   i_last         ACC: sample ends the accumulation
//   i_data         signed data operand   [A_WIDTH]
//   i_weight       signed weight operand [B_WIDTH]
//   i_partoutvalue signed partial sum C  [OUT_WIDTH]
//   o_en           result valid (3 cycles after i_en)
//   o_last         final ACC result of a frame
//   o_ovf          result left the OUT_WIDTH signed range
//   o_data         signed result         [OUT_WIDTH]

module pe_mac_pipe #(
  parameter int A_WIDTH   = 30,
  parameter int B_WIDTH   = 18,
  parameter int OUT_WIDTH = 48,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic [1:0]           i_mode,
  input  logic                 i_first,
  input  logic                 i_last,
  input  logic [A_WIDTH-1:0]   i_data,
  input  logic [B_WIDTH-1:0]   i_weight,
  input  logic [OUT_WIDTH-1:0] i_partoutvalue,
  output logic                 o_en,
  output logic                 o_last,
  output logic                 o_ovf,
  output logic [OUT_WIDTH-1:0] o_data
);

  localparam int PW = A_WIDTH + B_WIDTH;
  localparam int RW = OUT_WIDTH + 1;

  localparam logic [OUT_WIDTH-1:0] SAT_MAX =
    {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] SAT_MIN =
    {1'b1, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    MODE_MUL_ADD = 2'd0,
    MODE_MUL_SUB = 2'd1,
    MODE_MUL     = 2'd2,
    MODE_ACC     = 2'd3
  } mode_e;

  // ---------------- stage 1: operand capture
  logic                        s1_vld_q;
  logic signed [A_WIDTH-1:0]   s1_a_q;
  logic signed [B_WIDTH-1:0]   s1_b_q;
  logic signed [OUT_WIDTH-1:0] s1_c_q;
  mode_e                       s1_mode_q;
  logic                        s1_first_q;
  logic                        s1_last_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_vld_q   <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_c_q     <= '0;
      s1_mode_q  <= MODE_MUL_ADD;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
    end else begin
      s1_vld_q <= i_en;
      if (i_en) begin
        s1_a_q     <= i_data;
        s1_b_q     <= i_weight;
        s1_c_q     <= i_partoutvalue;
        s1_mode_q  <= mode_e'(i_mode);
        s1_first_q <= i_first;
        s1_last_q  <= i_last;
      end
    end
  end

  // ---------------- stage 2: full-width product
  logic signed [PW-1:0] prod;

  assign prod = PW'(s1_a_q) * PW'(s1_b_q);

  logic                        s2_vld_q;
  logic signed [RW-1:0]        s2_m_q;
  logic signed [OUT_WIDTH-1:0] s2_c_q;
  mode_e                       s2_mode_q;
  logic                        s2_first_q;
  logic                        s2_last_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_vld_q   <= 1'b0;
      s2_m_q     <= '0;
      s2_c_q     <= '0;
      s2_mode_q  <= MODE_MUL_ADD;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
    end else begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_m_q     <= RW'(prod);
        s2_c_q     <= s1_c_q;
        s2_mode_q  <= s1_mode_q;
        s2_first_q <= s1_first_q;
        s2_last_q  <= s1_last_q;
      end
    end
  end

  // ---------------- stage 3: add/sub/acc, range check, output
  logic                        o_en_q;
  logic                        o_last_q, o_last_d;
  logic                        o_ovf_q, o_ovf_d;
  logic signed [OUT_WIDTH-1:0] o_data_q, o_data_d;
  logic signed [OUT_WIDTH-1:0] acc_q, acc_d;

  logic signed [RW-1:0]        sum;
  logic                        ovf;
  logic [OUT_WIDTH-1:0]        res;
  logic                        is_acc;

  assign is_acc = (s2_mode_q == MODE_ACC);

  always_comb begin
    sum = s2_m_q;
    unique case (s2_mode_q)
      MODE_MUL_ADD: sum = RW'(s2_c_q) + s2_m_q;
      MODE_MUL_SUB: sum = RW'(s2_c_q) - s2_m_q;
      MODE_MUL:     sum = s2_m_q;
      MODE_ACC:     sum = s2_first_q ? s2_m_q
                                     : RW'(acc_q) + s2_m_q;
      default:      sum = s2_m_q;
    endcase
  end

  // One guard bit: out of range when the top two bits disagree.
  assign ovf = sum[RW-1] ^ sum[RW-2];

  always_comb begin
    res = sum[OUT_WIDTH-1:0];
    if (SATURATE && ovf) begin
      res = sum[RW-1] ? SAT_MIN : SAT_MAX;
    end
  end

  always_comb begin
    o_data_d = o_data_q;
    o_last_d = o_last_q;
    o_ovf_d  = o_ovf_q;
    acc_d    = acc_q;
    if (s2_vld_q) begin
      o_data_d = res;
      o_last_d = is_acc && s2_last_q;
      o_ovf_d  = ovf;
      // acc follows the stored (possibly clamped) result,
      // so the next term builds on what was actually output.
      if (is_acc) begin
        acc_d = res;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_en_q   <= 1'b0;
      o_last_q <= 1'b0;
      o_ovf_q  <= 1'b0;
      o_data_q <= '0;
      acc_q    <= '0;
    end else begin
      o_en_q   <= s2_vld_q;
      o_last_q <= o_last_d;
      o_ovf_q  <= o_ovf_d;
      o_data_q <= o_data_d;
      acc_q    <= acc_d;
    end
  end

  assign o_en   = o_en_q;
  assign o_last = o_last_q;
  assign o_ovf  = o_ovf_q;
  assign o_data = o_data_q;

endmodule

// File: tb/tb_pe_mac_pipe.sv
// Directed bench for pe_mac_pipe: a wrapping and a saturating
// instance share stimulus; expected values are hand computed.

module tb_pe_mac_pipe;

  logic               clk;
  logic               rst;
  logic               en;
  logic [1:0]         mode;
  logic               first;
  logic               last;
  logic signed [29:0] data;
  logic signed [17:0] wt;
  logic signed [47:0] cin;

  logic        w_en, w_last, w_ovf;
  logic [47:0] w_data;
  logic        s_en, s_last, s_ovf;
  logic [47:0] s_data;

  int checks   = 0;
  int failures = 0;

  pe_mac_pipe #(
    .A_WIDTH(30), .B_WIDTH(18),
    .OUT_WIDTH(48), .SATURATE(1'b0)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .i_mode(mode), .i_first(first), .i_last(last),
    .i_data(data), .i_weight(wt),
    .i_partoutvalue(cin),
    .o_en(w_en), .o_last(w_last),
    .o_ovf(w_ovf), .o_data(w_data)
  );

  pe_mac_pipe #(
    .A_WIDTH(30), .B_WIDTH(18),
    .OUT_WIDTH(48), .SATURATE(1'b1)
  ) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .i_mode(mode), .i_first(first), .i_last(last),
    .i_data(data), .i_weight(wt),
    .i_partoutvalue(cin),
    .o_en(s_en), .o_last(s_last),
    .o_ovf(s_ovf), .o_data(s_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setin(
    input logic               e,
    input logic [1:0]         m,
    input logic               f,
    input logic               l,
    input logic signed [29:0] d,
    input logic signed [17:0] w,
    input logic signed [47:0] cc
  );
    en    = e;
    mode  = m;
    first = f;
    last  = l;
    data  = d;
    wt    = w;
    cin   = cc;
  endtask

  task automatic idle();
    setin(1'b0, 2'd0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic chk(
    input string       tag,
    input logic [47:0] obs,
    input logic [47:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    chk("rst_en",   48'(w_en),   48'd0);
    chk("rst_last", 48'(w_last), 48'd0);
    chk("rst_ovf",  48'(w_ovf),  48'd0);
    chk("rst_data", w_data,      48'd0);
    rst = 1'b0;

    // MUL_ADD 3*-4+100 = 88, latency 3
    setin(1'b1, 2'd0, 1'b0, 1'b0, 30'sd3, -18'sd4, 48'sd100);
    tick();
    chk("ma_c1_en", 48'(w_en), 48'd0);
    idle();
    tick();
    chk("ma_c2_en", 48'(w_en), 48'd0);
    tick();
    chk("ma_c3_en",   48'(w_en),  48'd1);
    chk("ma_c3_data", w_data,     48'd88);
    chk("ma_c3_ovf",  48'(w_ovf), 48'd0);
    tick();
    chk("ma_c4_en",   48'(w_en), 48'd0);
    chk("ma_c4_hold", w_data,    48'd88);

    // back-to-back MUL_SUB, MUL, MUL_ADD
    setin(1'b1, 2'd1, 1'b0, 1'b0, 30'sd5, 18'sd6, 48'sd10);
    tick();
    setin(1'b1, 2'd2, 1'b0, 1'b0, -30'sd7, 18'sd8, 48'sd999);
    tick();
    setin(1'b1, 2'd0, 1'b0, 1'b0, 30'sd2, 18'sd2, -48'sd1);
    tick();
    chk("b2b_0_en",   48'(w_en), 48'd1);
    chk("b2b_0_data", w_data,    -48'sd20);
    idle();
    tick();
    chk("b2b_1_en",   48'(w_en), 48'd1);
    chk("b2b_1_data", w_data,    -48'sd56);
    tick();
    chk("b2b_2_en",   48'(w_en), 48'd1);
    chk("b2b_2_data", w_data,    48'd3);
    tick();
    chk("b2b_end_en", 48'(w_en), 48'd0);

    // ACC 10,30,(bubble x2),60,100 then restart
    setin(1'b1, 2'd3, 1'b1, 1'b0, 30'sd1, 18'sd10, '0);
    tick();
    setin(1'b1, 2'd3, 1'b0, 1'b0, 30'sd2, 18'sd10, '0);
    tick();
    idle();
    tick();
    chk("acc0_data", w_data,     48'd10);
    chk("acc0_last", 48'(w_last), 48'd0);
    tick();
    chk("acc1_data", w_data,     48'd30);
    chk("acc1_last", 48'(w_last), 48'd0);
    setin(1'b1, 2'd3, 1'b0, 1'b0, 30'sd3, 18'sd10, '0);
    tick();
    chk("acc_bub0_en", 48'(w_en), 48'd0);
    setin(1'b1, 2'd3, 1'b0, 1'b1, 30'sd4, 18'sd10, '0);
    tick();
    chk("acc_bub1_en", 48'(w_en), 48'd0);
    setin(1'b1, 2'd3, 1'b1, 1'b0, 30'sd1, 18'sd10, '0);
    tick();
    chk("acc2_data", w_data,     48'd60);
    chk("acc2_last", 48'(w_last), 48'd0);
    idle();
    tick();
    chk("acc3_en",   48'(w_en),   48'd1);
    chk("acc3_data", w_data,      48'd100);
    chk("acc3_last", 48'(w_last), 48'd1);
    tick();
    chk("acc_rs_data", w_data,     48'd10);
    chk("acc_rs_last", 48'(w_last), 48'd0);
    tick();
    chk("acc_drain_en", 48'(w_en), 48'd0);

    // non-ACC leaves acc alone; ACC first=0 continues from 10
    setin(1'b1, 2'd2, 1'b1, 1'b1, 30'sd5, 18'sd5, '0);
    tick();
    setin(1'b1, 2'd3, 1'b0, 1'b0, 30'sd1, 18'sd1, '0);
    tick();
    idle();
    tick();
    chk("mix_mul_data", w_data,      48'd25);
    chk("mix_mul_last", 48'(w_last), 48'd0);
    tick();
    chk("mix_acc_data", w_data, 48'd11);

    // overflow: positive and negative, wrap vs clamp
    setin(1'b1, 2'd0, 1'b0, 1'b0, 30'sd1, 18'sd1,
          48'sh7FFF_FFFF_FFFF);
    tick();
    setin(1'b1, 2'd1, 1'b0, 1'b0, 30'sd1, 18'sd1,
          48'sh8000_0000_0000);
    tick();
    setin(1'b1, 2'd2, 1'b0, 1'b0, 30'sd2, 18'sd3, '0);
    tick();
    chk("povf_wrap",     w_data,     48'h8000_0000_0000);
    chk("povf_wrap_ovf", 48'(w_ovf), 48'd1);
    chk("povf_sat",      s_data,     48'h7FFF_FFFF_FFFF);
    chk("povf_sat_ovf",  48'(s_ovf), 48'd1);
    idle();
    tick();
    chk("novf_wrap",     w_data,     48'h7FFF_FFFF_FFFF);
    chk("novf_wrap_ovf", 48'(w_ovf), 48'd1);
    chk("novf_sat",      s_data,     48'h8000_0000_0000);
    chk("novf_sat_ovf",  48'(s_ovf), 48'd1);
    tick();
    chk("ovf_clr_data", w_data,     48'd6);
    chk("ovf_clr_ovf",  48'(w_ovf), 48'd0);
    chk("ovf_clr_sovf", 48'(s_ovf), 48'd0);
    tick();

    // reset with three samples in flight
    setin(1'b1, 2'd2, 1'b0, 1'b0, 30'sd7, 18'sd7, '0);
    tick();
    setin(1'b1, 2'd2, 1'b0, 1'b0, 30'sd8, 18'sd8, '0);
    tick();
    setin(1'b1, 2'd2, 1'b0, 1'b0, 30'sd9, 18'sd9, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    chk("flr_en0",   48'(w_en), 48'd0);
    chk("flr_data0", w_data,    48'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flr_en", 48'(w_en), 48'd0);
    end
    chk("flr_data", w_data, 48'd0);

    // acc cleared by reset: first=0 starts from 0
    setin(1'b1, 2'd3, 1'b0, 1'b0, 30'sd2, 18'sd3, '0);
    tick();
    idle();
    tick();
    tick();
    chk("acc0_en",   48'(w_en), 48'd1);
    chk("acc0_from", w_data,    48'd6);

    // extreme operands
    setin(1'b1, 2'd2, 1'b0, 1'b0, 30'sh2000_0000, 18'sh2_0000, '0);
    tick();
    idle();
    tick();
    tick();
    chk("minmax_data",  w_data,     48'h4000_0000_0000);
    chk("minmax_ovf",   48'(w_ovf), 48'd0);
    chk("minmax_sdata", s_data,     48'h4000_0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
